// File: rtl/ahb_pkg.sv
// Shared AHB encodings for htrans and hburst, plus the burst-length helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BurstSingle = 3'b000,
    BurstIncr   = 3'b001,
    BurstWrap4  = 3'b010,
    BurstIncr4  = 3'b011,
    BurstWrap8  = 3'b100,
    BurstIncr8  = 3'b101,
    BurstWrap16 = 3'b110,
    BurstIncr16 = 3'b111
  } hburst_e;

  // Undefined-length INCR counts as a single beat so arbitration stays open.
  function automatic logic [4:0] beats(input logic [2:0] burst);
    logic [4:0] n;
    case (burst)
      BurstWrap4,  BurstIncr4:  n = 5'd4;
      BurstWrap8,  BurstIncr8:  n = 5'd8;
      BurstWrap16, BurstIncr16: n = 5'd16;
      default:                  n = 5'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational request selector: lowest index in fixed mode, or first
// requester above the pointer (wrapping to the lowest) in round-robin mode.
module ahb_arb_pick
  import ahb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 16
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [3:0]           ptr,
  input  logic                 rr_mode,
  output logic [3:0]           idx
);

  logic [N_MASTERS-1:0] hi;
  logic [N_MASTERS-1:0] src;

  always_comb begin
    hi = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      hi[i] = req[i] && (4'(i) > ptr);
    end
    src = (rr_mode && (|hi)) ? hi : req;
    idx = '0;
    for (int i = int'(N_MASTERS) - 1; i >= 0; i--) begin
      if (src[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// AHB bus arbiter: registered one-hot grant, burst-length hold, locked-transfer
// hold, fixed or round-robin selection.
module ahb_arbiter_rr
  import ahb_pkg::*;
#(
  parameter int unsigned N_MASTERS      = 16,
  parameter int unsigned RR_MODE        = 1,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic [N_MASTERS-1:0] hbusreq,
  input  logic [N_MASTERS-1:0] hlock,
  input  logic [1:0]           htrans,
  input  logic [2:0]           hburst,
  input  logic                 hready,
  output logic [N_MASTERS-1:0] hgrant,
  output logic [3:0]           hmaster,
  output logic [3:0]           hmaster_d,
  output logic                 hmastlock
);

  localparam logic [N_MASTERS-1:0] GrantOne = {{(N_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [3:0]           DefIdx   = 4'(DEFAULT_MASTER);
  localparam logic                 RrMode   = (RR_MODE != 0);

  logic [3:0]           cnt_q, cnt_d;
  logic [3:0]           ptr_q;
  logic [3:0]           master_q, master_dp_q;
  logic [N_MASTERS-1:0] grant_q;
  logic                 lock_q;

  logic [15:0] lock_all;
  logic [3:0]  pick_idx, next_idx;
  logic        req_any, open;

  ahb_arb_pick #(
    .N_MASTERS (N_MASTERS)
  ) u_pick (
    .req     (hbusreq),
    .ptr     (ptr_q),
    .rr_mode (RrMode),
    .idx     (pick_idx)
  );

  always_comb begin
    cnt_d = cnt_q;
    case (htrans)
      TransNonseq: cnt_d = 4'(beats(hburst) - 5'd1);
      TransSeq:    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      TransIdle:   cnt_d = '0;
      default:     cnt_d = cnt_q;
    endcase
    // Zero-extended so an index never selects a lock bit beyond N_MASTERS.
    lock_all = 16'(hlock);
    open     = (cnt_d == 4'd0) && !lock_all[master_q];
    req_any  = |hbusreq;
    next_idx = req_any ? pick_idx : DefIdx;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      cnt_q       <= '0;
      ptr_q       <= DefIdx;
      master_q    <= DefIdx;
      master_dp_q <= DefIdx;
      grant_q     <= GrantOne << DEFAULT_MASTER;
      lock_q      <= 1'b0;
    end else if (hready) begin
      cnt_q       <= cnt_d;
      master_dp_q <= master_q;
      if (open) begin
        master_q <= next_idx;
        grant_q  <= GrantOne << next_idx;
        lock_q   <= lock_all[next_idx];
        if (req_any) ptr_q <= next_idx;
      end
    end
  end

  assign hgrant    = grant_q;
  assign hmaster   = master_q;
  assign hmaster_d = master_dp_q;
  assign hmastlock = lock_q;

endmodule

// File: doc/ahb_arbiter_rr.md
AHB_ARBITER_RR -- requirements
Module: ahb_arbiter_rr

Interface
REQ-001 SHALL have parameter N_MASTERS, default 16, number of requesting masters (2..16).
REQ-002 SHALL have parameter RR_MODE, default 1, where 1 means round-robin and 0 means fixed priority (index 0 highest).
REQ-003 SHALL have parameter DEFAULT_MASTER, default 0, the master granted when there are no requests.
REQ-004 SHALL have port hclk, input, 1 bit: the single clock.
REQ-005 SHALL have port hreset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port hbusreq, input, N_MASTERS bits: bus request per master.
REQ-007 SHALL have port hlock, input, N_MASTERS bits: locked-transfer request per master.
REQ-008 SHALL have port htrans, input, 2 bits: transfer type of the current bus owner.
REQ-009 SHALL have port hburst, input, 3 bits: burst type of the current bus owner.
REQ-010 SHALL have port hready, input, 1 bit: transfer-complete signal from the bus.
REQ-011 SHALL have port hgrant, output, N_MASTERS bits: one-hot grant.
REQ-012 SHALL have port hmaster, output, 4 bits: index of the address-phase owner.
REQ-013 SHALL have port hmaster_d, output, 4 bits: index of the data-phase owner.
REQ-014 SHALL have port hmastlock, output, 1 bit: the current address phase is locked.

Function
REQ-015 SHALL update hgrant, hmaster and hmastlock only on a rising hclk with hready=1 and re-arbitration open; all three are registered, with no combinational path from input to output.
REQ-016 SHALL hold a beat counter with the following behaviour:
- load beats-1 on an accepted NONSEQ (beats: INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16, otherwise 1);
- decrement on an accepted SEQ;
- clear on an accepted IDLE.
REQ-017 SHALL open re-arbitration only when the counter value after that edge is 0 and hlock[hmaster]=0.
REQ-018 SHALL, in fixed mode, grant the lowest-index requester.
REQ-019 SHALL, in round-robin mode, search from pointer+1 upward with wrap at N_MASTERS-1 to 0, and set the pointer to the newly granted index.
REQ-020 SHALL grant DEFAULT_MASTER when hbusreq is all zero; the round-robin pointer is not updated in that case.
REQ-021 SHALL keep the current grant when the current master is still requesting and re-arbitration is closed, even if a higher-priority request appears.
REQ-022 SHALL set hmastlock to hlock of the newly granted master, registered together with the grant.
REQ-023 SHALL load hmaster_d from hmaster on every rising hclk with hready=1, and hold it while hready=0.
REQ-024 SHALL ignore hbusreq and hlock bits at index N_MASTERS or above.
REQ-025 SHALL treat an hready=0 cycle as a stall: counter, pointer and grant are all frozen.
REQ-026 SHALL grant a request that rises in the same edge that opens re-arbitration, and the grant appears one cycle later.
REQ-027 SHALL never leave hgrant anything other than exactly one-hot.

Reset
REQ-028 SHALL, while hreset=1, set hgrant=onehot(DEFAULT_MASTER), hmaster=DEFAULT_MASTER, hmaster_d=DEFAULT_MASTER, hmastlock=0, counter=0 and pointer=DEFAULT_MASTER, asynchronously.
REQ-029 SHALL, when reset is asserted mid-burst, abandon the burst with no residual lock, and the first arbitration after release SHALL be open.

Structure
REQ-030 SHALL take the htrans encodings (IDLE, BUSY, NONSEQ, SEQ), the hburst encodings and a beats(hburst) function from the shared package ahb_pkg.
REQ-031 SHALL place request selection in the combinational sub-module ahb_arb_pick (inputs: requests, pointer, mode; output: index).
REQ-032 SHALL keep the counter, pointer, grant and lock registers in the top module only.

Verification
REQ-033 Fixed mode, N=4, hbusreq=4'b1010, hready=1 -> hgrant=4'b0010 and hmaster=1 after one edge.
REQ-034 Round-robin mode, N=4, all four masters requesting continuously with SINGLE transfers -> hmaster sequence 1,2,3,0,1.
REQ-035 Master 2 issues INCR4 and master 0 then requests -> grant held for 4 accepted beats, then switches to 0; two hready=0 stalls extend the hold by 2 cycles.
REQ-036 Master 3 holds hlock=1 with hbusreq from others -> hgrant stays 4'b1000 and hmastlock=1 until hlock drops, then the grant moves on.
REQ-037 hbusreq=0 with DEFAULT_MASTER=2 -> hgrant=4'b0100; hreset asserted mid-INCR8 -> outputs return to reset values immediately, with no clock edge required.
REQ-038 The bench SHALL check hmaster_d against hmaster lagging by one hready-qualified cycle, and SHALL assert hgrant one-hot on every cycle.
